bram_stream_reader: RTL

- Read-side master for the team's `bram_t` byte memories, such as the simulation ROMs and the sequence/quality BRAMs.
- Accepts a (start address, length) command and issues `read_en`/`read_addr` to the BRAM slave, which has a 1-cycle registered read latency.
- Returns the bytes as a valid/ready stream with a last-flag, at a sustained rate of 1 byte/cycle under full backpressure tolerance.
- Feeds the pair-HMM read/haplotype loaders.

---
 rtl/bram_stream_reader_if.sv | 34 +++
 rtl/bram_stream_reader.sv | 132 +++++++++++++
 2 files changed

// File: rtl/bram_stream_reader_if.sv
// Handshake bundle for bram_stream_reader: command channel, BRAM read port and output stream.
//   master : the reader (takes the command, drives the BRAM read and the output stream)
//   slave  : the environment (issues commands, models the BRAM, consumes the stream)
// Signals:
//   cmd_valid/cmd_ready/cmd_addr/cmd_length    command handshake
//   bram_read_en/bram_read_addr/bram_read_data BRAM read port (1-cycle registered latency)
//   out_valid/out_ready/out_data/out_last      byte stream
//   done                                       one-cycle completion pulse
interface bram_stream_reader_if #(
  parameter int unsigned ADDR_WIDTH = 10
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [ADDR_WIDTH:0]   cmd_length;
  logic                  bram_read_en;
  logic [ADDR_WIDTH-1:0] bram_read_addr;
  logic [7:0]            bram_read_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [7:0]            out_data;
  logic                  out_last;
  logic                  done;

  modport master (
    input  cmd_valid, cmd_addr, cmd_length, bram_read_data, out_ready,
    output cmd_ready, bram_read_en, bram_read_addr, out_valid, out_data, out_last, done
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_length, bram_read_data, out_ready,
    input  cmd_ready, bram_read_en, bram_read_addr, out_valid, out_data, out_last, done
  );
endinterface

// File: rtl/bram_stream_reader.sv
// Read-side master for bram_t byte memories. Takes a (start address, length) command, reads the
// BRAM one byte per cycle through a 3-entry FIFO and returns a valid/ready byte stream with a
// last flag, followed by a one-cycle done pulse.
// Ports:
//   clock  single clock for the block and the attached BRAM
//   reset  asynchronous, active-high reset; aborts any command in progress
//   bus    bram_stream_reader_if.master (command, BRAM read port, output stream, done)
// Optional feature: define BRAM_READER_OFFSET_SUB_EN to subtract OFFSET (8-bit wrap) from every
// byte before it enters the FIFO; otherwise bytes pass unmodified and OFFSET is ignored.
module bram_stream_reader #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter logic [7:0]  OFFSET     = 8'd0
) (
  input logic                   clock,
  input logic                   reset,
  bram_stream_reader_if.master  bus
);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   remaining_q;
  logic                  inflight_q;
  logic                  inflight_last_q;
  logic [7:0]            fifo_data_q [3];
  logic [2:0]            fifo_last_q;
  logic [1:0]            wr_ptr_q;
  logic [1:0]            rd_ptr_q;
  logic [1:0]            count_q;

  logic                  accept;
  logic                  issue;
  logic                  push;
  logic                  pop;
  logic                  final_issue;
  logic [7:0]            push_data;

  assign accept = bus.cmd_valid && bus.cmd_ready;

  // Credit rule: bytes in the FIFO plus the one in flight never exceed 3, so a push can never
  // hit a full FIFO. Deliberately independent of out_ready.
  assign issue = (state_q == StFetch) && (remaining_q != '0) &&
                 (({1'b0, count_q} + {2'b00, inflight_q}) < 3'd3);
  assign final_issue = issue && (remaining_q == {{ADDR_WIDTH{1'b0}}, 1'b1});

  assign push = inflight_q;
  assign pop  = bus.out_valid && bus.out_ready;

`ifdef BRAM_READER_OFFSET_SUB_EN
  assign push_data = bus.bram_read_data - OFFSET;
`else
  assign push_data = bus.bram_read_data;
  logic unused_offset;
  assign unused_offset = ^OFFSET;
`endif

  assign bus.cmd_ready      = (state_q == StIdle) && !reset;
  assign bus.bram_read_en   = issue;
  assign bus.bram_read_addr = addr_q;
  assign bus.out_valid      = (count_q != 2'd0);
  assign bus.out_data       = fifo_data_q[rd_ptr_q];
  assign bus.out_last       = fifo_last_q[rd_ptr_q];
  assign bus.done           = (state_q == StDone);

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= StIdle;
      addr_q          <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      fifo_data_q[0]  <= 8'd0;
      fifo_data_q[1]  <= 8'd0;
      fifo_data_q[2]  <= 8'd0;
      fifo_last_q     <= 3'b000;
      wr_ptr_q        <= 2'd0;
      rd_ptr_q        <= 2'd0;
      count_q         <= 2'd0;
    end else begin
      // Read pipeline: BRAM data for a read issued last cycle is present now.
      inflight_q      <= issue;
      inflight_last_q <= final_issue;
      if (push) begin
        fifo_data_q[wr_ptr_q] <= push_data;
        fifo_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q              <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};

      if (issue) begin
        addr_q      <= addr_q + ADDR_WIDTH'(1);
        remaining_q <= remaining_q - (ADDR_WIDTH + 1)'(1);
      end

      unique case (state_q)
        StIdle: begin
          if (accept) begin
            addr_q      <= bus.cmd_addr;
            remaining_q <= bus.cmd_length;
            // A zero-length command passes through DRAIN (already empty), so done
            // lands two cycles after acceptance.
            state_q     <= (bus.cmd_length == '0) ? StDrain : StFetch;
          end
        end
        StFetch: begin
          if (final_issue) state_q <= StDrain;
        end
        StDrain: begin
          // Nothing in flight and either empty, or the last byte leaves this cycle.
          if (!inflight_q && ((count_q == 2'd0) || ((count_q == 2'd1) && pop))) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
